// File: rtl/fractal_sync_nary_if.sv
// Barrier-node bundle: downstream slave-side request/wake lines, upstream master-side
// request/wake lines and the completion counters.
interface fractal_sync_nary_if #(
  parameter int N_SLV     = 4,
  parameter int SLV_WIDTH = 3,
  parameter int CNT_WIDTH = 16
);
  logic [N_SLV-1:0]           slv_sync_i;
  logic [N_SLV*SLV_WIDTH-1:0] slv_level_i;
  logic [N_SLV-1:0]           slv_wake_o;
  logic [N_SLV-1:0]           slv_error_o;
  logic [N_SLV-1:0]           slv_ack_i;
  logic                       mst_sync_o;
  logic [SLV_WIDTH-2:0]       mst_level_o;
  logic                       mst_wake_i;
  logic                       mst_error_i;
  logic                       mst_ack_o;
  logic [CNT_WIDTH-1:0]       barrier_cnt_o;
  logic [CNT_WIDTH-1:0]       error_cnt_o;

  modport slave (
    input  slv_sync_i, slv_level_i, slv_ack_i, mst_wake_i, mst_error_i,
    output slv_wake_o, slv_error_o, mst_sync_o, mst_level_o, mst_ack_o,
           barrier_cnt_o, error_cnt_o
  );

  modport master (
    output slv_sync_i, slv_level_i, slv_ack_i, mst_wake_i, mst_error_i,
    input  slv_wake_o, slv_error_o, mst_sync_o, mst_level_o, mst_ack_o,
           barrier_cnt_o, error_cnt_o
  );
endinterface

// File: rtl/fractal_sync_nary.sv
// N-ary barrier node: collects N_SLV slave requests at a common level, resolves level 1
// locally, forwards higher levels upstream one level down, then releases the participants.
module fractal_sync_nary #(
  parameter int N_SLV     = 4,
  parameter int SLV_WIDTH = 3,
  parameter int TIMEOUT   = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  fractal_sync_nary_if.slave   s
);
  localparam int LVL_MAX = 2 ** (SLV_WIDTH - 1);
  localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, FWD, WAKE} state_t;

  state_t                 state_q, state_d;
  logic [N_SLV-1:0]       arr_q, arr_d;
  logic                   err_q, err_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [N_SLV-1:0]       wake_q, wake_d;
  logic [N_SLV-1:0]       werr_q, werr_d;
  logic                   msync_q, msync_d;
  logic [SLV_WIDTH-2:0]   mlvl_q, mlvl_d;
  logic                   mack_q, mack_d;
  logic [CNT_WIDTH-1:0]   bcnt_q, bcnt_d;
  logic [CNT_WIDTH-1:0]   ecnt_q, ecnt_d;
  logic [SLV_WIDTH-1:0]   lvl_q;
  logic                   lvl_ld;

  logic [SLV_WIDTH-1:0]   lvl [N_SLV];
  logic [N_SLV-1:0]       new_arr;
  logic [SLV_WIDTH-1:0]   first_lvl;
  logic [SLV_WIDTH-1:0]   ref_lvl;
  logic                   found;
  logic                   lvl_mis;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic lvl_bad(input logic [SLV_WIDTH-1:0] l);
    return (l == '0) || (int'(l) > LVL_MAX);
  endfunction

  // New arrivals and their agreement with the barrier level (lowest index wins on a tie).
  always_comb begin
    new_arr   = s.slv_sync_i & ~arr_q;
    first_lvl = '0;
    found     = 1'b0;
    lvl_mis   = 1'b0;
    for (int i = 0; i < N_SLV; i++) begin
      lvl[i] = s.slv_level_i[i*SLV_WIDTH +: SLV_WIDTH];
      if (new_arr[i] && !found) begin
        first_lvl = lvl[i];
        found     = 1'b1;
      end
    end
    ref_lvl = (state_q == IDLE) ? first_lvl : lvl_q;
    for (int i = 0; i < N_SLV; i++)
      if (new_arr[i] && (lvl[i] != ref_lvl)) lvl_mis = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    arr_d   = arr_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    wake_d  = wake_q;
    werr_d  = werr_q;
    msync_d = msync_q;
    mlvl_d  = mlvl_q;
    mack_d  = 1'b0;
    bcnt_d  = bcnt_q;
    ecnt_d  = ecnt_q;
    lvl_ld  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|new_arr) begin
          state_d = COLLECT;
          arr_d   = new_arr;
          lvl_ld  = 1'b1;
          err_d   = lvl_mis | lvl_bad(first_lvl);
          tmo_d   = '0;
        end
      end
      COLLECT: begin
        arr_d = arr_q | new_arr;
        err_d = err_q | lvl_mis;
        if (&arr_q) begin
          if (err_q || (lvl_q == SLV_WIDTH'(1))) begin
            state_d = WAKE;
            wake_d  = arr_q;
            werr_d  = arr_q & {N_SLV{err_q}};
          end else begin
            state_d = FWD;
            msync_d = 1'b1;
            // L <= 2^(SLV_WIDTH-1), so the low bits minus one give L-1 exactly.
            mlvl_d  = lvl_q[SLV_WIDTH-2:0] - 1'b1;
          end
        end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          state_d = WAKE;
          err_d   = 1'b1;
          arr_d   = arr_q | new_arr;
          wake_d  = arr_q | new_arr;
          werr_d  = arr_q | new_arr;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      FWD: begin
        if (s.mst_wake_i) begin
          state_d = WAKE;
          msync_d = 1'b0;
          mlvl_d  = '0;
          mack_d  = 1'b1;
          err_d   = err_q | s.mst_error_i;
          wake_d  = arr_q;
          werr_d  = arr_q & {N_SLV{err_q | s.mst_error_i}};
        end
      end
      WAKE: begin
        wake_d = wake_q & ~s.slv_ack_i;
        werr_d = werr_q & ~s.slv_ack_i;
        if (wake_d == '0) begin
          state_d = IDLE;
          arr_d   = '0;
          err_d   = 1'b0;
          bcnt_d  = sat_inc(bcnt_q);
          if (err_q) ecnt_d = sat_inc(ecnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      arr_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      wake_q  <= '0;
      werr_q  <= '0;
      msync_q <= 1'b0;
      mlvl_q  <= '0;
      mack_q  <= 1'b0;
      bcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      arr_q   <= arr_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      wake_q  <= wake_d;
      werr_q  <= werr_d;
      msync_q <= msync_d;
      mlvl_q  <= mlvl_d;
      mack_q  <= mack_d;
      bcnt_q  <= bcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

  // Barrier level is only read while arr_q is non-zero, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (lvl_ld) lvl_q <= first_lvl;
  end

  assign s.slv_wake_o    = wake_q;
  assign s.slv_error_o   = werr_q;
  assign s.mst_sync_o    = msync_q;
  assign s.mst_level_o   = mlvl_q;
  assign s.mst_ack_o     = mack_q;
  assign s.barrier_cnt_o = bcnt_q;
  assign s.error_cnt_o   = ecnt_q;
endmodule

// File: tb/tb_fractal_sync_nary.sv
// Directed bench for fractal_sync_nary: local, forwarded, mismatched, timed-out and
// reset-interrupted barriers with hand-computed expectations.
module tb_fractal_sync_nary;
  localparam int N_SLV = 4;
  localparam int SLV_WIDTH = 3;
  localparam int TIMEOUT = 20;
  localparam int CNT_WIDTH = 16;

  logic clk_i;
  logic rstn_i;
  int   nvec = 0;
  int   nerr = 0;

  fractal_sync_nary_if #(.N_SLV(N_SLV), .SLV_WIDTH(SLV_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  fractal_sync_nary #(
    .N_SLV(N_SLV), .SLV_WIDTH(SLV_WIDTH), .TIMEOUT(TIMEOUT), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .s      (bus.slave)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn_i          = 1'b1;
    bus.slv_sync_i  = '0;
    bus.slv_level_i = '0;
    bus.slv_ack_i   = '0;
    bus.mst_wake_i  = 1'b0;
    bus.mst_error_i = 1'b0;
    #2 rstn_i = 1'b0;
    #2;
    check("rst_wake",  32'(bus.slv_wake_o),    32'h0);
    check("rst_err",   32'(bus.slv_error_o),   32'h0);
    check("rst_msync", 32'(bus.mst_sync_o),    32'h0);
    check("rst_mlvl",  32'(bus.mst_level_o),   32'h0);
    check("rst_mack",  32'(bus.mst_ack_o),     32'h0);
    check("rst_bcnt",  32'(bus.barrier_cnt_o), 32'h0);
    check("rst_ecnt",  32'(bus.error_cnt_o),   32'h0);
    tick(); tick();
    @(negedge clk_i) rstn_i = 1'b1;
    tick();

    // Level-1 barrier, staggered arrivals, released one cycle after the last sample.
    bus.slv_level_i = {3'd1, 3'd1, 3'd1, 3'd1};
    bus.slv_sync_i  = 4'b0001; tick();
    tick();
    bus.slv_sync_i  = 4'b0101; tick();
    bus.slv_sync_i  = 4'b0111; tick();
    tick();
    bus.slv_sync_i  = 4'b1111; tick();
    check("l1_wake_early", 32'(bus.slv_wake_o), 32'h0);
    tick();
    check("l1_wake",  32'(bus.slv_wake_o),  32'hf);
    check("l1_err",   32'(bus.slv_error_o), 32'h0);
    check("l1_msync", 32'(bus.mst_sync_o),  32'h0);
    bus.slv_ack_i  = 4'b1111;
    bus.slv_sync_i = 4'b0000; tick();
    bus.slv_ack_i  = 4'b0000;
    check("l1_wake_clr", 32'(bus.slv_wake_o),    32'h0);
    check("l1_bcnt",     32'(bus.barrier_cnt_o), 32'd1);
    check("l1_ecnt",     32'(bus.error_cnt_o),   32'd0);

    // Level-3 barrier forwarded as level 2; upstream releases with error.
    bus.slv_level_i = {3'd3, 3'd3, 3'd3, 3'd3};
    bus.slv_sync_i  = 4'b1111; tick();
    tick();
    check("fw_msync", 32'(bus.mst_sync_o),  32'h1);
    check("fw_mlvl",  32'(bus.mst_level_o), 32'h2);
    check("fw_wake0", 32'(bus.slv_wake_o),  32'h0);
    bus.mst_wake_i  = 1'b1;
    bus.mst_error_i = 1'b1; tick();
    bus.mst_wake_i  = 1'b0;
    bus.mst_error_i = 1'b0;
    check("fw_msync_drop", 32'(bus.mst_sync_o),  32'h0);
    check("fw_mack",       32'(bus.mst_ack_o),   32'h1);
    check("fw_wake",       32'(bus.slv_wake_o),  32'hf);
    check("fw_err",        32'(bus.slv_error_o), 32'hf);
    tick();
    check("fw_mack_once",  32'(bus.mst_ack_o),   32'h0);
    check("fw_wake_hold",  32'(bus.slv_wake_o),  32'hf);
    bus.slv_ack_i  = 4'b1111;
    bus.slv_sync_i = 4'b0000; tick();
    bus.slv_ack_i  = 4'b0000;
    check("fw_bcnt", 32'(bus.barrier_cnt_o), 32'd2);
    check("fw_ecnt", 32'(bus.error_cnt_o),   32'd1);

    // Level mismatch (slave 3 asks for 1), then acks returned in reverse order.
    bus.slv_level_i = {3'd1, 3'd2, 3'd2, 3'd2};
    bus.slv_sync_i  = 4'b0111; tick();
    tick();
    bus.slv_sync_i  = 4'b1111; tick();
    check("mm_msync0", 32'(bus.mst_sync_o), 32'h0);
    tick();
    check("mm_msync1", 32'(bus.mst_sync_o),  32'h0);
    check("mm_wake",   32'(bus.slv_wake_o),  32'hf);
    check("mm_err",    32'(bus.slv_error_o), 32'hf);
    bus.slv_ack_i = 4'b1000; bus.slv_sync_i = 4'b0111; tick();
    check("rv_wake3", 32'(bus.slv_wake_o),    32'h7);
    check("rv_err3",  32'(bus.slv_error_o),   32'h7);
    check("rv_bcnt3", 32'(bus.barrier_cnt_o), 32'd2);
    bus.slv_ack_i = 4'b0100; bus.slv_sync_i = 4'b0011; tick();
    check("rv_wake2", 32'(bus.slv_wake_o), 32'h3);
    bus.slv_ack_i = 4'b0010; bus.slv_sync_i = 4'b0001; tick();
    check("rv_wake1", 32'(bus.slv_wake_o), 32'h1);
    bus.slv_ack_i = 4'b0001; bus.slv_sync_i = 4'b0000; tick();
    bus.slv_ack_i = 4'b0000;
    check("rv_wake0", 32'(bus.slv_wake_o),    32'h0);
    check("rv_bcnt",  32'(bus.barrier_cnt_o), 32'd3);
    check("rv_ecnt",  32'(bus.error_cnt_o),   32'd2);

    // Timeout: only slaves 0 and 1 arrive.
    bus.slv_level_i = {3'd1, 3'd1, 3'd1, 3'd1};
    bus.slv_sync_i  = 4'b0011; tick();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("to_wake_early", 32'(bus.slv_wake_o), 32'h0);
    tick();
    check("to_wake", 32'(bus.slv_wake_o),  32'h3);
    check("to_err",  32'(bus.slv_error_o), 32'h3);
    bus.slv_sync_i = 4'b1111; tick();
    check("to_late_ignored", 32'(bus.slv_wake_o), 32'h3);
    bus.slv_ack_i  = 4'b0011;
    bus.slv_sync_i = 4'b1100; tick();
    bus.slv_ack_i  = 4'b0000;
    check("to_bcnt", 32'(bus.barrier_cnt_o), 32'd4);
    check("to_ecnt", 32'(bus.error_cnt_o),   32'd3);
    tick();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("to2_wake_early", 32'(bus.slv_wake_o), 32'h0);
    tick();
    check("to2_wake", 32'(bus.slv_wake_o),  32'hc);
    check("to2_err",  32'(bus.slv_error_o), 32'hc);
    bus.slv_ack_i  = 4'b1100;
    bus.slv_sync_i = 4'b0000; tick();
    bus.slv_ack_i  = 4'b0000;
    check("to2_bcnt", 32'(bus.barrier_cnt_o), 32'd5);
    check("to2_ecnt", 32'(bus.error_cnt_o),   32'd4);

    // Out-of-range level 5 is resolved locally with error.
    bus.slv_level_i = {3'd5, 3'd5, 3'd5, 3'd5};
    bus.slv_sync_i  = 4'b1111; tick();
    tick();
    check("bad_msync", 32'(bus.mst_sync_o),  32'h0);
    check("bad_wake",  32'(bus.slv_wake_o),  32'hf);
    check("bad_err",   32'(bus.slv_error_o), 32'hf);
    bus.slv_ack_i  = 4'b1111;
    bus.slv_sync_i = 4'b0000; tick();
    bus.slv_ack_i  = 4'b0000;
    check("bad_ecnt", 32'(bus.error_cnt_o), 32'd5);

    // Reset while forwarding, then a clean level-1 barrier.
    bus.slv_level_i = {3'd2, 3'd2, 3'd2, 3'd2};
    bus.slv_sync_i  = 4'b1111; tick();
    tick();
    check("rf_msync", 32'(bus.mst_sync_o),  32'h1);
    check("rf_mlvl",  32'(bus.mst_level_o), 32'h1);
    #2 rstn_i = 1'b0;
    #1;
    check("rf_msync_async", 32'(bus.mst_sync_o),    32'h0);
    check("rf_mlvl_async",  32'(bus.mst_level_o),   32'h0);
    check("rf_bcnt_async",  32'(bus.barrier_cnt_o), 32'h0);
    bus.slv_sync_i = 4'b0000;
    @(negedge clk_i) rstn_i = 1'b1;
    tick();
    check("rf_no_wake", 32'(bus.slv_wake_o), 32'h0);
    check("rf_no_ack",  32'(bus.mst_ack_o),  32'h0);
    bus.slv_level_i = {3'd1, 3'd1, 3'd1, 3'd1};
    bus.slv_sync_i  = 4'b1111; tick();
    tick();
    check("rf_wake", 32'(bus.slv_wake_o),  32'hf);
    check("rf_err",  32'(bus.slv_error_o), 32'h0);
    bus.slv_ack_i  = 4'b1111;
    bus.slv_sync_i = 4'b0000; tick();
    bus.slv_ack_i  = 4'b0000;
    check("rf_bcnt", 32'(bus.barrier_cnt_o), 32'd1);
    check("rf_ecnt", 32'(bus.error_cnt_o),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fractal_sync_nary.md
FRACTAL_SYNC_NARY -- requirements
Module: fractal_sync_nary

Interface
Parameters (one per line: name, default, meaning):
REQ-001 SHALL have N_SLV, 4, slave-port fan-in; legal range 2..16.
REQ-002 SHALL have SLV_WIDTH, 3, slave level width; master level width is SLV_WIDTH-1; SLV_WIDTH >= 2.
REQ-003 SHALL have TIMEOUT, 0, cycles allowed from first arrival to full barrier; 0 disables the timeout.
REQ-004 SHALL have CNT_WIDTH, 16, width of the status counters.

Ports (name  direction  width  meaning):
REQ-005 SHALL have clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have rstn_i  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have slv_sync_i  in  N_SLV  per-slave barrier request.
REQ-008 SHALL have slv_level_i  in  N_SLV*SLV_WIDTH  per-slave requested level.
REQ-009 SHALL have slv_wake_o  out  N_SLV  per-slave barrier release.
REQ-010 SHALL have slv_error_o  out  N_SLV  per-slave error flag, valid while slv_wake_o is high.
REQ-011 SHALL have slv_ack_i  in  N_SLV  per-slave wake acknowledge.
REQ-012 SHALL have mst_sync_o  out  1  upstream barrier request.
REQ-013 SHALL have mst_level_o  out  SLV_WIDTH-1  upstream level.
REQ-014 SHALL have mst_wake_i  in  1  upstream release.
REQ-015 SHALL have mst_error_i  in  1  upstream error, sampled with mst_wake_i.
REQ-016 SHALL have mst_ack_o  out  1  upstream wake acknowledge.
REQ-017 SHALL have barrier_cnt_o  out  CNT_WIDTH  completed barriers, saturating.
REQ-018 SHALL have error_cnt_o  out  CNT_WIDTH  barriers released with error, saturating.

Function
REQ-019 SHALL follow the slave protocol: slave holds sync/level stable until wake; node holds wake/error until ack; slave drops sync no later than its ack cycle.
REQ-020 SHALL implement FSM states IDLE, COLLECT, FWD, WAKE; IDLE->COLLECT on first sampled slv_sync_i.
REQ-021 SHALL latch the first arrival's level as barrier level L; simultaneous first arrivals with unequal levels set the error flag.
REQ-022 SHALL set the error flag in COLLECT on: a later arrival with level != L; L == 0; L > 2^(SLV_WIDTH-1).
REQ-023 SHALL move COLLECT->WAKE one cycle after all N_SLV arrivals are sampled, when L == 1 or the error flag is set.
REQ-024 SHALL move COLLECT->FWD one cycle after all N_SLV arrivals are sampled, when L > 1 and no error; in FWD, mst_sync_o = 1 and mst_level_o = L-1.
REQ-025 SHALL, in FWD, sample mst_wake_i = 1 and OR mst_error_i into the error flag.
REQ-026 SHALL, in the cycle after that sample: drop mst_sync_o, pulse mst_ack_o for exactly one cycle, and enter WAKE.
REQ-027 SHALL, in WAKE, drive slv_wake_o/slv_error_o to every participating slave and clear each bit the cycle after its slv_ack_i is sampled.
REQ-028 SHALL move WAKE->IDLE when all participating slaves have acked (acks may arrive in any order or together).
REQ-029 SHALL, with TIMEOUT != 0, count cycles in COLLECT from the first arrival; on reaching TIMEOUT before full arrival, set the error flag, enter WAKE, and release only the slaves that have arrived.
REQ-030 SHALL ignore non-participating slaves during WAKE; their requests are collected in a fresh barrier after IDLE.
REQ-031 SHALL increment barrier_cnt_o on every WAKE->IDLE, and error_cnt_o also when the error flag was set; both saturate at all-ones.
REQ-032 SHALL ignore slv_ack_i without a pending wake, and mst_wake_i outside FWD.
REQ-033 SHALL drive all outputs from registers; no combinational path from any input to any output.

Reset
REQ-034 SHALL, when rstn_i = 0, immediately force: FSM to IDLE, slv_wake_o = 0, slv_error_o = 0, mst_sync_o = 0, mst_level_o = 0, mst_ack_o = 0, all counters and flags = 0.
REQ-035 SHALL abandon any barrier in progress on reset mid-operation; after release the first cycle is IDLE, with no spurious wake or ack.

Verification
REQ-036 SHALL pass: N_SLV = 4, all slaves request level 1 at random cycles -> slv_wake_o = 4'b1111, error = 0, one cycle after the last arrival; barrier_cnt_o = 1.
REQ-037 SHALL pass: all slaves request level 3 -> mst_sync_o = 1, mst_level_o = 2; upstream wake with error = 1 -> mst_ack_o pulses once, all slaves woken with error = 1, error_cnt_o = 1.
REQ-038 SHALL pass: slaves 0-2 request level 2, slave 3 requests level 1 -> no mst_sync_o, all four woken with error = 1.
REQ-039 SHALL pass: TIMEOUT = 20, only slaves 0 and 1 arrive -> 20 cycles later slv_wake_o = 4'b0011 with error = 1; slaves 2 and 3 then form a new barrier.
REQ-040 SHALL pass: rstn_i low while in FWD -> mst_sync_o = 0 asynchronously; a later level-1 barrier completes normally with barrier_cnt_o = 1.
REQ-041 SHALL pass: acks returned in reverse order over 4 cycles -> each slv_wake_o bit falls the cycle after its own ack; IDLE after the last one.
